// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the in-order pipeline hazard controller:
// opcode map, control FSM states and the scoreboard tracker entry.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_SUBI = 6'h03;
    localparam logic [5:0] OP_AND  = 6'h04;
    localparam logic [5:0] OP_ANDI = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_XOR  = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h09;
    localparam logic [5:0] OP_SLT  = 6'h0A;
    localparam logic [5:0] OP_SLTI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    // Tracker depth: one entry each for EX, MEM and WB.
    localparam int NUM_TRK = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
    } trk_entry_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op <= OP_SLT) && !op[0];
    endfunction

endpackage

// File: rtl/hazard_ctrl_hz_decode.sv
// Combinational register-usage decode: which sources an instruction reads
// and which destination it writes (r0 reported as neither).
module hz_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        src1_v_o,
    output logic [4:0]  src1_o,
    output logic        src2_v_o,
    output logic [4:0]  src2_o,
    output logic        dst_v_o,
    output logic [4:0]  dst_o,
    output logic        is_halt_o
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       use_rs;
    logic       use_rt;
    logic       wr_rd;
    logic       wr_rt;
    logic       unused_imm;

    assign op         = inst_i[31:26];
    assign rs         = inst_i[25:21];
    assign rt         = inst_i[20:16];
    assign rd         = inst_i[15:11];
    assign unused_imm = ^inst_i[10:0];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        wr_rd  = 1'b0;
        wr_rt  = 1'b0;
        if (is_rtype(op)) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            wr_rd  = 1'b1;
        end else if ((op <= OP_SLTI) || (op == OP_LDW)) begin
            use_rs = 1'b1;
            wr_rt  = 1'b1;
        end else if ((op == OP_STW) || (op == OP_BEQ)) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if ((op == OP_BZ) || (op == OP_JR)) begin
            use_rs = 1'b1;
        end
    end

    // r0 is hardwired, so it never creates or resolves a dependency.
    assign src1_o    = rs;
    assign src1_v_o  = use_rs && (rs != 5'd0);
    assign src2_o    = rt;
    assign src2_v_o  = use_rt && (rt != 5'd0);
    assign dst_o     = wr_rd ? rd : rt;
    assign dst_v_o   = (wr_rd || wr_rt) && (dst_o != 5'd0);
    assign is_halt_o = (op == OP_HALT);

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock controller for a 5-stage pipeline without forwarding: stalls ID
// on RAW hazards, flushes on taken branches and drains the pipe on HALT.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       src1_v;
    logic [4:0] src1;
    logic       src2_v;
    logic [4:0] src2;
    logic       dst_v;
    logic [4:0] dst;
    logic       is_halt;

    trk_entry_t [NUM_TRK-1:0] trk_q;
    trk_entry_t [NUM_TRK-1:0] trk_d;
    trk_entry_t               ex_next;
    logic [NUM_TRK-1:0]       hit;
    logic [NUM_TRK-1:0]       live;
    state_t                   state_q;
    logic                     halted_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     hazard;
    logic                     run;
    logic                     issue;

    hz_decode u_id_decode (
        .inst_i    (id_inst),
        .src1_v_o  (src1_v),
        .src1_o    (src1),
        .src2_v_o  (src2_v),
        .src2_o    (src2),
        .dst_v_o   (dst_v),
        .dst_o     (dst),
        .is_halt_o (is_halt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRK; gi++) begin : g_cmp
            assign live[gi] = trk_q[gi].v;
            assign hit[gi]  = trk_q[gi].v &&
                              ((src1_v && (src1 == trk_q[gi].dst)) ||
                               (src2_v && (src2 == trk_q[gi].dst)));
        end
    endgenerate

    assign hazard = |hit;
    assign run    = (state_q == ST_RUN);

    // Outputs are masked while reset is asserted so that a stale DRAIN/HALTED
    // state or pending hazard has no effect in the reset cycle itself.
    always_comb begin
        flush  = br_taken;
        stall  = reset && ((hazard && id_valid && !br_taken) || !run);
        bubble = !reset || stall || br_taken || !id_valid;
        issue  = reset && id_valid && !hazard && !br_taken && run;
    end

    always_comb begin
        ex_next.v   = issue && dst_v;
        ex_next.dst = (issue && dst_v) ? dst : 5'd0;
        trk_d       = {trk_q[NUM_TRK-2:0], ex_next};
        cnt_d       = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            trk_q <= '0;
            cnt_q <= '0;
        end else begin
            trk_q <= trk_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (issue && is_halt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (live == '0) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expectations from an abstract register-history model.
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [31:0]      id_inst;
    logic             br_taken;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .br_taken  (br_taken),
        .stall     (stall),
        .bubble    (bubble),
        .flush     (flush),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        bit stall;
        bit bubble;
        bit flush;
        bit halted;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: destinations written by the instructions that issued
    // 1, 2 and 3 cycles ago (0 = nothing), drain/halt mode, stall count.
    int hist[3];
    int mode;      // 0 running, 1 draining, 2 halted
    int m_cnt;

    function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic void ref_decode(input logic [31:0] w, output int s1, output int s2,
                                       output int d, output bit halt);
        int op;
        op   = int'(w[31:26]);
        s1   = 0;
        s2   = 0;
        d    = 0;
        halt = (op == 17);
        if (op <= 10 && op % 2 == 0) begin
            s1 = int'(w[25:21]); s2 = int'(w[20:16]); d = int'(w[15:11]);
        end else if ((op <= 11 && op % 2 == 1) || op == 12) begin
            s1 = int'(w[25:21]); d = int'(w[20:16]);
        end else if (op == 13 || op == 15) begin
            s1 = int'(w[25:21]); s2 = int'(w[20:16]);
        end else if (op == 14 || op == 16) begin
            s1 = int'(w[25:21]);
        end
    endfunction

    function automatic bit pending(input int r);
        return (r != 0) && (hist[0] == r || hist[1] == r || hist[2] == r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; expected response goes to the scoreboard.
    task automatic cyc(input bit v, input logic [31:0] inst, input bit br, input bit rn);
        exp_t e;
        int   s1, s2, d;
        bit   halt, haz, iss;
        id_valid = v;
        id_inst  = inst;
        br_taken = br;
        rst_n    = rn;
        e.flush  = br;
        e.halted = (mode == 2);
        e.cnt    = m_cnt;
        if (!rn) begin
            e.stall  = 1'b0;
            e.bubble = 1'b1;
            hist     = '{0, 0, 0};
            mode     = 0;
            m_cnt    = 0;
        end else begin
            ref_decode(inst, s1, s2, d, halt);
            haz      = pending(s1) || pending(s2);
            e.stall  = (haz && v && !br) || (mode != 0);
            e.bubble = e.stall || br || !v;
            iss      = v && !haz && !br && (mode == 0);
            if (mode == 1 && hist[0] == 0 && hist[1] == 0 && hist[2] == 0) mode = 2;
            else if (mode == 0 && iss && halt) mode = 1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = iss ? d : 0;
            if (e.stall && m_cnt < CNT_MAX) m_cnt++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",     int'(stall),     int'(e.stall));
                check("bubble",    int'(bubble),    int'(e.bubble));
                check("flush",     int'(flush),     int'(e.flush));
                check("halted",    int'(halted),    int'(e.halted));
                check("stall_cnt", int'(stall_cnt), e.cnt);
                $display("[TB] txn %0d: stall=%0b bubble=%0b flush=%0b halted=%0b cnt=%0d",
                         n, stall, bubble, flush, halted, stall_cnt);
                n++;
            end
        end
    end

    initial begin : driver
        logic [31:0] w;
        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_inst  = '0;
        br_taken = 1'b0;
        hist     = '{0, 0, 0};
        mode     = 0;
        m_cnt    = 0;
        @(posedge clk);
        #1;
        cyc(0, 32'h0, 0, 0);
        cyc(0, 32'h0, 1, 0);

        // add r3,r1,r2 ; add r4,r3,r1 -> three stall cycles then issue
        cyc(1, enc(0, 1, 2, 3), 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, enc(0, 3, 1, 4), 0, 1);
        cyc(0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1);

        // addi r0,r1,5 ; add r2,r0,r0 -> no stall
        cyc(1, enc(1, 1, 0, 0) | 32'd5, 0, 1);
        cyc(1, enc(0, 0, 0, 2), 0, 1);

        // stw r7,0(r1) ; add r8,r7,r7 -> no stall
        cyc(1, enc(13, 1, 7, 0), 0, 1);
        cyc(1, enc(0, 7, 7, 8), 0, 1);

        // hazard coincident with taken branch, then consumer of the squashed dest
        cyc(1, enc(0, 10, 11, 5), 0, 1);
        cyc(1, enc(0, 12, 13, 9), 0, 1);
        cyc(0, 32'h0, 0, 1);
        cyc(0, 32'h0, 0, 1);
        cyc(1, enc(0, 9, 9, 6), 1, 1);
        cyc(1, enc(0, 6, 6, 7), 0, 1);

        // two writers, HALT, long drain/halt hold saturates the counter, then reset
        cyc(0, 32'h0, 0, 0);
        cyc(1, enc(0, 4, 5, 1), 0, 1);
        cyc(1, enc(0, 4, 5, 2), 0, 1);
        cyc(1, enc(17, 0, 0, 0), 1, 1);
        cyc(1, enc(17, 0, 0, 0), 0, 1);
        for (int i = 0; i < 22; i++) cyc(1, enc(0, 1, 2, 3), (i % 7) == 3, 1);
        cyc(0, 32'h0, 0, 0);
        cyc(1, enc(0, 1, 2, 3), 0, 1);
        cyc(0, 32'h0, 0, 1);

        // reset in the middle of a stall
        cyc(1, enc(0, 1, 2, 3), 0, 1);
        cyc(1, enc(0, 3, 3, 4), 0, 1);
        cyc(1, enc(0, 3, 3, 4), 0, 0);
        cyc(1, enc(0, 3, 3, 4), 0, 1);

        for (int i = 0; i < 500; i++) begin
            w = enc($urandom_range(0, 19), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3)) | 32'($urandom_range(0, 2047));
            cyc($urandom_range(0, 4) != 0, w, $urandom_range(0, 6) == 0,
                $urandom_range(0, 39) != 0);
        end

        id_valid = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
